// File: rtl/sram_arb_pkg.sv
// Shared types for the external SRAM arbiter: FSM states, grant encoding,
// counter width and the strobe decode used to register the SRAM control pins.
package sram_arb_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  typedef struct packed {
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic dq_oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1,
                                      lb_n: 1'b1, dq_oe: 1'b0};

  // Strobe levels for the cycle spent in state st. Reads always enable both
  // byte lanes; writes keep data driven through RECOVER for hold time.
  function automatic strobe_t strobe_decode(input state_e st, input logic we,
                                            input logic [1:0] be);
    strobe_t s;
    s = STROBE_IDLE;
    if (st == ST_ACCESS) begin
      if (we) begin
        s.we_n  = 1'b0;
        s.ub_n  = ~be[1];
        s.lb_n  = ~be[0];
        s.dq_oe = 1'b1;
      end else begin
        s.oe_n = 1'b0;
        s.ub_n = 1'b0;
        s.lb_n = 1'b0;
      end
    end else if (st == ST_RECOVER) begin
      s.dq_oe = we;
    end
    return s;
  endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Winner select for the SRAM arbiter: B has priority, but A is forced through
// once B has won MAX_B_STREAK times in a row while A was waiting.
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter int MAX_B_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   a_req,
  input  logic   b_req,
  input  logic   update,
  output grant_e grant,
  output logic   grant_valid
);

  localparam cnt_t STREAK_MAX = cnt_t'(MAX_B_STREAK);

  cnt_t streak_q, streak_d;

  always_comb begin
    grant_valid = a_req | b_req;
    if (b_req && !(a_req && (streak_q == STREAK_MAX))) begin
      grant = GNT_B;
    end else begin
      grant = GNT_A;
    end

    streak_d = streak_q;
    if (update && grant_valid) begin
      // Only B wins against a waiting A count toward starving A.
      if ((grant == GNT_B) && a_req) begin
        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the 16-bit asynchronous SRAM: sequences each access
// with a programmable strobe width and returns results over req/ack.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int WAIT_CYCLES  = 2,
  parameter int MAX_B_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  input  logic [1:0]        a_be,
  output logic              a_ack,
  output logic [15:0]       a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  input  logic [1:0]        b_be,
  output logic              b_ack,
  output logic [15:0]       b_rdata,

  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy
);

  state_e            state_q, state_d;
  cnt_t              wait_q, wait_d;
  grant_e            gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic [15:0]       a_rdata_q, a_rdata_d;
  logic [15:0]       b_rdata_q, b_rdata_d;
  strobe_t           strobe_q, strobe_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;

  grant_e            grant;
  logic              grant_valid;
  logic              grant_update;

  sram_arb_grant #(
    .MAX_B_STREAK (MAX_B_STREAK)
  ) u_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .b_req       (b_req),
    .update      (grant_update),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    // NOTE: every signal written here is given its hold value first, so no
    // branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    wait_d       = wait_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    grant_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_update = 1'b1;
        if (grant_valid) begin
          gnt_d = grant;
          if (grant == GNT_B) begin
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            be_d    = b_be;
          end else begin
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            be_d    = a_be;
          end
          wait_d  = cnt_t'(WAIT_CYCLES - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          if (!we_q) begin
            if (gnt_q == GNT_B) begin
              b_rdata_d = sram_dq_i;
            end else begin
              a_rdata_d = sram_dq_i;
            end
          end
          state_d = ST_RECOVER;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Pins are registered from the next state so the async SRAM never sees
    // decode glitches on WE/OE.
    strobe_d = strobe_decode(state_d, we_d, be_d);
    a_ack_d  = (state_d == ST_RECOVER) && (gnt_d == GNT_A);
    b_ack_d  = (state_d == ST_RECOVER) && (gnt_d == GNT_B);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values;
    // the reset is synchronous, so an abandoned access drops its strobes on
    // the very edge that samples rst_n low.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      gnt_q     <= GNT_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      strobe_q  <= STROBE_IDLE;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      strobe_q  <= strobe_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = strobe_q.dq_oe;
  assign sram_oe_n  = strobe_q.oe_n;
  assign sram_we_n  = strobe_q.we_n;
  assign sram_ub_n  = strobe_q.ub_n;
  assign sram_lb_n  = strobe_q.lb_n;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=2 instance with a byte-lane
// SRAM model, plus a WAIT_CYCLES=1 instance for the short-strobe cases.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance with WAIT_CYCLES = 2
  logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [19:0] a_addr, b_addr, sram_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [1:0]  a_be, b_be;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy;

  // Instance with WAIT_CYCLES = 1
  logic        u_a_req, u_a_we, u_a_ack, u_b_req, u_b_we, u_b_ack;
  logic [19:0] u_a_addr, u_b_addr, u_sram_addr;
  logic [15:0] u_a_wdata, u_b_wdata, u_a_rdata, u_b_rdata;
  logic [1:0]  u_a_be, u_b_be;
  logic [15:0] u_sram_dq_i, u_sram_dq_o;
  logic        u_sram_dq_oe, u_sram_oe_n, u_sram_we_n, u_sram_ub_n, u_sram_lb_n, u_busy;

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(2), .MAX_B_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1), .MAX_B_STREAK(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(u_a_req), .a_we(u_a_we), .a_addr(u_a_addr), .a_wdata(u_a_wdata), .a_be(u_a_be),
    .a_ack(u_a_ack), .a_rdata(u_a_rdata),
    .b_req(u_b_req), .b_we(u_b_we), .b_addr(u_b_addr), .b_wdata(u_b_wdata), .b_be(u_b_be),
    .b_ack(u_b_ack), .b_rdata(u_b_rdata),
    .sram_addr(u_sram_addr), .sram_dq_i(u_sram_dq_i), .sram_dq_o(u_sram_dq_o),
    .sram_dq_oe(u_sram_dq_oe), .sram_oe_n(u_sram_oe_n), .sram_we_n(u_sram_we_n),
    .sram_ub_n(u_sram_ub_n), .sram_lb_n(u_sram_lb_n), .busy(u_busy)
  );

  // SRAM models: 256 words indexed by addr[7:0], word i preset to {i, ~i}.
  logic [15:0] mem  [256];
  logic [15:0] mem1 [256];

  assign sram_dq_i   = sram_oe_n   ? 16'h0000 : mem[sram_addr[7:0]];
  assign u_sram_dq_i = u_sram_oe_n ? 16'h0000 : mem1[u_sram_addr[7:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= {i[7:0], ~i[7:0]};
        mem1[i] <= {i[7:0], ~i[7:0]};
      end
      mem[8'h34]  <= 16'hBEEF;
      mem1[8'h34] <= 16'hA5C3;
    end else begin
      if (!sram_we_n) begin
        if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
        if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
      end
      if (!u_sram_we_n) begin
        if (!u_sram_ub_n) mem1[u_sram_addr[7:0]][15:8] <= u_sram_dq_o[15:8];
        if (!u_sram_lb_n) mem1[u_sram_addr[7:0]][7:0]  <= u_sram_dq_o[7:0];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        port_b;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_word;  // read data for reads; memory word afterwards for both
  } vec_t;

  // One transaction on the WAIT_CYCLES=2 instance; latency counted in cycles
  // from the request cycle to the ack cycle (0 = no ack within the bound).
  task automatic run_vec(input vec_t v, output int lat, output logic [19:0] addr_seen,
                         output logic [15:0] rd, output logic wrong_ack);
    lat       = 0;
    addr_seen = '0;
    rd        = '0;
    wrong_ack = 1'b0;
    if (v.port_b) begin
      b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_be = v.be; b_req = 1'b1;
    end else begin
      a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_be = v.be; a_req = 1'b1;
    end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) addr_seen = sram_addr;
      if (v.port_b ? a_ack : b_ack) wrong_ack = 1'b1;
      if (v.port_b ? b_ack : a_ack) begin
        lat = n;
        rd  = v.port_b ? b_rdata : a_rdata;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  // Cycle-by-cycle trace of one port-A access; bit 3 holds cycle 1.
  task automatic trace_a(input logic we, input logic [19:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, output logic [3:0] t_oe, output logic [3:0] t_we,
                         output logic [3:0] t_ub, output logic [3:0] t_lb, output logic [3:0] t_dq,
                         output logic [3:0] t_ack, output logic [3:0] t_busy, output logic [15:0] rd);
    a_we = we; a_addr = addr; a_wdata = wd; a_be = be; a_req = 1'b1;
    rd = '0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      t_oe[4-n]   = sram_oe_n;
      t_we[4-n]   = sram_we_n;
      t_ub[4-n]   = sram_ub_n;
      t_lb[4-n]   = sram_lb_n;
      t_dq[4-n]   = sram_dq_oe;
      t_ack[4-n]  = a_ack;
      t_busy[4-n] = busy;
      if (a_ack) begin
        rd    = a_rdata;
        a_req = 1'b0;
      end
    end
    a_req = 1'b0;
  endtask

  vec_t        vecs [9];
  int          lat, cnt, nb, na, b_before;
  int          t_ack_b [3];
  logic [19:0] addr_seen;
  logic [15:0] rd;
  logic        wrong, both;
  logic [3:0]  t_oe, t_we, t_ub, t_lb, t_dq, t_ack, t_busy;
  logic [9:0]  order;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 20'h01234, 16'h0000, 2'b11, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 20'h00010, 16'h5AA5, 2'b10, 16'h5AEF};
    vecs[2] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 2'b00, 16'h5AEF};
    vecs[3] = '{1'b1, 1'b1, 20'h00020, 16'h9966, 2'b01, 16'h2066};
    vecs[4] = '{1'b1, 1'b0, 20'h00020, 16'h0000, 2'b11, 16'h2066};
    vecs[5] = '{1'b1, 1'b1, 20'h00020, 16'h1234, 2'b11, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 20'h00010, 16'hFFFF, 2'b00, 16'h5AEF};
    vecs[7] = '{1'b1, 1'b0, 20'h01234, 16'h0000, 2'b11, 16'hBEEF};
    vecs[8] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 2'b01, 16'h1234};

    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    u_a_req = 0; u_a_we = 0; u_a_addr = 0; u_a_wdata = 0; u_a_be = 0;
    u_b_req = 0; u_b_we = 0; u_b_addr = 0; u_b_wdata = 0; u_b_be = 0;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_sram_addr", sram_addr, 20'h0);
    check("rst_dq_o", sram_dq_o, 16'h0);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'hF);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_rdata", {a_rdata, b_rdata}, 32'h0);
    check("rst_busy", {busy, u_busy}, 2'b00);
    rst_n = 1'b1;
    tick();

    // Single A read with strobe timing
    trace_a(1'b0, 20'h01234, 16'h0, 2'b11, t_oe, t_we, t_ub, t_lb, t_dq, t_ack, t_busy, rd);
    check("rd_oe_n", t_oe, 4'b0011);
    check("rd_we_n", t_we, 4'b1111);
    check("rd_ub_lb", {t_ub, t_lb}, 8'b0011_0011);
    check("rd_dq_oe", t_dq, 4'b0000);
    check("rd_ack", t_ack, 4'b0010);
    check("rd_busy", t_busy, 4'b1110);
    check("rd_data", rd, 16'hBEEF);

    // Upper-byte A write
    trace_a(1'b1, 20'h00010, 16'h5AA5, 2'b10, t_oe, t_we, t_ub, t_lb, t_dq, t_ack, t_busy, rd);
    check("wr_oe_n", t_oe, 4'b1111);
    check("wr_we_n", t_we, 4'b0011);
    check("wr_ub_n", t_ub, 4'b0011);
    check("wr_lb_n", t_lb, 4'b1111);
    check("wr_dq_oe", t_dq, 4'b1110);
    check("wr_ack", t_ack, 4'b0010);
    check("wr_mem", mem[8'h10], 16'h5AEF);
    check("wr_a_rdata_held", a_rdata, 16'hBEEF);

    // Table of single transactions
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], lat, addr_seen, rd, wrong);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_addr", i), addr_seen, vecs[i].addr);
      check($sformatf("vec%0d_other_ack", i), wrong, 1'b0);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_word);
      check($sformatf("vec%0d_mem", i), mem[vecs[i].addr[7:0]], vecs[i].exp_word);
    end

    // Both requesters held: B x4, A, B x4, A
    a_we = 0; a_addr = 20'h01234; b_we = 0; b_addr = 20'h00020;
    a_req = 1; b_req = 1;
    order = '0; cnt = 0; both = 0;
    for (int n = 0; n < 200 && cnt < 10; n++) begin
      tick();
      if (a_ack && b_ack) both = 1'b1;
      if (a_ack || b_ack) begin
        order = {order[8:0], b_ack};
        cnt++;
      end
    end
    a_req = 0; b_req = 0;
    tick(); tick();
    check("arb_count", cnt, 10);
    check("arb_order", order, 10'b1111011110);
    check("arb_no_double_ack", both, 1'b0);
    check("arb_b_rdata", b_rdata, 16'h1234);

    // Streak builds to 2, A drops (streak clears), B streams back-to-back
    a_req = 1; b_req = 1;
    nb = 0; na = 0;
    for (int n = 0; n < 300 && nb < 4; n++) begin
      tick();
      if (a_ack) na++;
      if (b_ack) begin
        nb++;
        if (nb >= 2) t_ack_b[nb-2] = n;
        if (nb == 2) a_req = 0;
      end
    end
    check("stream_b_acks", nb, 4);
    check("stream_no_a", na, 0);
    check("stream_gap1", t_ack_b[1] - t_ack_b[0], 4);
    check("stream_gap2", t_ack_b[2] - t_ack_b[1], 4);
    a_req = 1;
    b_before = 0; na = 0;
    for (int n = 0; n < 300 && na == 0; n++) begin
      tick();
      if (b_ack) b_before++;
      if (a_ack) na++;
    end
    a_req = 0; b_req = 0;
    tick(); tick();
    check("streak_cleared_a_seen", na, 1);
    check("streak_cleared_b_first", b_before, 4);

    // WAIT_CYCLES = 1: read, then be=00 write
    u_a_we = 0; u_a_addr = 20'h00034; u_a_req = 1;
    tick();
    check("w1_rd_c1_oe_n", u_sram_oe_n, 1'b0);
    check("w1_rd_c1_ack", u_a_ack, 1'b0);
    tick();
    check("w1_rd_c2_ack", u_a_ack, 1'b1);
    check("w1_rd_c2_rdata", u_a_rdata, 16'hA5C3);
    check("w1_rd_c2_oe_n", u_sram_oe_n, 1'b1);
    u_a_req = 0;
    tick();
    check("w1_rd_c3_busy", u_busy, 1'b0);
    u_a_we = 1; u_a_wdata = 16'h0000; u_a_be = 2'b00; u_a_req = 1;
    tick();
    check("w1_be0_c1_we_n", u_sram_we_n, 1'b0);
    check("w1_be0_c1_ub_lb", {u_sram_ub_n, u_sram_lb_n}, 2'b11);
    check("w1_be0_c1_dq_oe", u_sram_dq_oe, 1'b1);
    tick();
    check("w1_be0_c2_ack", u_a_ack, 1'b1);
    check("w1_be0_c2_ub_lb", {u_sram_ub_n, u_sram_lb_n}, 2'b11);
    check("w1_be0_c2_dq_oe", u_sram_dq_oe, 1'b1);
    u_a_req = 0;
    tick();
    check("w1_be0_c3_dq_oe", u_sram_dq_oe, 1'b0);
    check("w1_be0_mem", mem1[8'h34], 16'hA5C3);

    // Reset during ACCESS of a write; the held request is served afterwards
    a_we = 1; a_addr = 20'h00040; a_wdata = 16'h1357; a_be = 2'b01; a_req = 1;
    tick();
    check("rstmid_pre_we_n", sram_we_n, 1'b0);
    rst_n = 1'b0;
    tick();
    check("rstmid_we_n", sram_we_n, 1'b1);
    check("rstmid_dq_oe", sram_dq_oe, 1'b0);
    check("rstmid_ack", a_ack, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    rst_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (a_ack) begin
        lat = n;
        break;
      end
    end
    a_req = 0;
    tick();
    check("rstmid_reserve_latency", lat, 3);
    check("rstmid_reserve_mem", mem[8'h40], 16'h4057);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's 16-bit asynchronous external SRAM (20-bit word address, active-low OE/WE/UB/LB) between two requesters.
- Port A is the CPU/system side; port B is a streaming client (video line fetch or audio DMA).
- Sequences every async access with a programmable access-time counter and hands the result back over a req/ack handshake.
- Instantiated inside system, beside the SDRAM controller; the top level converts sram_dq_o/sram_dq_oe into the tristate SRAM_DQ bus.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 2, clk cycles the strobe is held per access; legal range 1..15.
- MAX_B_STREAK, 4, consecutive B grants allowed while A is pending; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  port A request level; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  16  port A write data.
- a_be  in  2  port A byte enables, active high; [1] = upper byte.
- a_ack  out  1  one-cycle completion pulse to port A.
- a_rdata  out  16  port A read data; valid while a_ack is high and held until the next A read completes.
- b_req, b_we, b_addr, b_wdata, b_be, b_ack, b_rdata: identical set for port B.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_i  in  16  SRAM data in.
- sram_dq_o  out  16  SRAM data out.
- sram_dq_oe  out  1  data bus drive enable.
- sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: rst_n is sampled low on a clk edge and forces state IDLE. After reset:
  - sram_addr = 0, sram_dq_o = 0, sram_dq_oe = 0.
  - sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n = 1.
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0, streak = 0.
- Reset mid-access: the in-flight access is abandoned, no ack is issued, and the strobes deassert on the same edge.
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata/be, load wait_cnt = WAIT_CYCLES - 1, and go to ACCESS.
- ACCESS:
  - sram_addr holds the latched address.
  - Read: sram_oe_n = 0, sram_ub_n = sram_lb_n = 0, sram_dq_oe = 0.
  - Write: sram_we_n = 0, sram_ub_n = ~be[1], sram_lb_n = ~be[0], sram_dq_oe = 1, sram_dq_o = latched wdata.
  - wait_cnt decrements each cycle. On the cycle where wait_cnt == 0:
    - a read captures sram_dq_i into the winner's rdata register;
    - next state is RECOVER.
- RECOVER:
  - sram_oe_n = sram_we_n = 1 and sram_ub_n = sram_lb_n = 1.
  - Address holds. For a write, data is still driven with sram_dq_oe = 1 (hold time); for a read, sram_dq_oe = 0.
  - The winner's ack is high for exactly this cycle.
  - Next state is IDLE, and sram_dq_oe = 0 from IDLE onward.
- Latency: a req seen in IDLE at edge k gives ack high in cycle k+WAIT_CYCLES+1. An access therefore costs WAIT_CYCLES+2 cycles, and the maximum rate is one access per WAIT_CYCLES+2 cycles.
- Handshake:
  - A requester keeps req high with stable fields until it sees ack.
  - A req still high in the cycle after ack is a new request; the requester updates its fields on the ack edge.
  - Requests are never dropped.
- Arbitration (evaluated only in IDLE):
  - B has priority.
  - If A and B are both pending and streak == MAX_B_STREAK, A wins.
  - streak increments when B wins while A is pending.
  - streak clears when A wins, or when B wins with A not pending.
  - streak saturates at MAX_B_STREAK.
- be = 00 write: a full cycle runs with the WE pulse but UB/LB stay high, so memory is unchanged; ack is still issued.
- Reads ignore be and always read both bytes.

Decomposition:
- Shared package sram_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, RECOVER = 2'd2);
  - grant encoding GNT_A = 1'b0, GNT_B = 1'b1;
  - the 4-bit wait/streak counter width.
- One sub-module, sram_arb_grant: combinational winner select plus the registered streak counter. Inputs are a_req, b_req and an update strobe asserted in IDLE; outputs are grant and grant_valid.
- The FSM, datapath latches and strobes stay in sram_arbiter.

Test Plan:
- Single A read, WAIT_CYCLES = 2, SRAM model returns 16'hBEEF at addr 20'h01234:
  - a_req at cycle 0 gives sram_oe_n low in cycles 1-2 and a_ack plus a_rdata = BEEF in cycle 3;
  - busy is high in cycles 1-3.
- A write, addr 20'h00010, wdata 16'h5AA5, be = 2'b10:
  - sram_we_n and sram_ub_n are low in cycles 1-2, sram_lb_n stays high;
  - sram_dq_oe is high in cycles 1-3;
  - the model's upper byte becomes 5A and the lower byte is unchanged.
- A and B both held high continuously, MAX_B_STREAK = 4: the grant order is B, B, B, B, A, B, B, B, B, A and no request is lost.
- B back-to-back with a_req low: consecutive b_ack pulses are exactly WAIT_CYCLES+2 = 4 cycles apart and streak stays 0.
- rst_n driven low during ACCESS of a write: on the next edge sram_we_n = 1, sram_dq_oe = 0, no ack, and state is IDLE; a held req is re-served after rst_n returns high.
- WAIT_CYCLES = 1 read: ack appears in cycle 2, and the be = 00 write case acks with UB/LB held high throughout.
